// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: PLL reset/lock sequencer with paced dynamic phase-step requests.
// Define PLL_PHASE_CTRL_POS_EN to add phase_pos, a saturating net step position per clock index.
module pll_phase_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 1024,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int STEP_GAP     = 8,
    parameter int STEP_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    output logic              pll_rst,
    output logic [2:0]        phase_sel,
    output logic              phase_dir,
    output logic              phase_step_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              locked,
    output logic              busy,
    output logic              done,
    output logic              lock_lost
`ifdef PLL_PHASE_CTRL_POS_EN
    ,
    output logic [79:0]       phase_pos
`endif
);
    typedef enum logic [2:0] {PRST, WAIT_LOCK, IDLE, STEP, GAP, DONE} state_t;
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int GW = $clog2(STEP_GAP + 1);
    state_t state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [2:0] sel_q, sel_d;
    logic dir_q, dir_d;
    logic lock_meta_q, lock_s_q;
    logic lost;

    assign phase_sel = sel_q;
    assign phase_dir = dir_q;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        filt_d    = '0;
        tmo_d     = '0;
        gap_d     = '0;
        steps_d   = steps_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        lost      = 1'b0;
        case (state_q)
            PRST: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                filt_d = lock_s_q ? filt_q + 1'b1 : '0;
                tmo_d  = tmo_q + 1'b1;
                if (lock_s_q && filt_q == FW'(LOCK_FILTER - 1)) state_d = IDLE;
                else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) state_d = PRST;
            end
            IDLE: begin
                if (req_valid) begin
                    sel_d   = (req_sel > 3'd4) ? 3'd0 : req_sel;
                    dir_d   = req_dir;
                    steps_d = req_steps;
                    state_d = (req_steps == '0) ? DONE : STEP;
                end
            end
            STEP: begin
                steps_d = steps_q - 1'b1;
                state_d = GAP;
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(STEP_GAP - 1)) state_d = (steps_q != '0) ? STEP : DONE;
            end
            default: state_d = IDLE;
        endcase
        // Losing lock after qualification overrides any request progress, including the done pulse.
        if (state_q inside {IDLE, STEP, GAP, DONE} && !lock_s_q) begin
            state_d = PRST;
            sel_d   = sel_q;
            dir_d   = dir_q;
            lost    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PRST;
            rst_cnt_q    <= '0;
            filt_q       <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            steps_q      <= '0;
            sel_q        <= '0;
            dir_q        <= 1'b0;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_rst      <= 1'b1;
            phase_step_n <= 1'b1;
            req_ready    <= 1'b0;
            locked       <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            filt_q       <= filt_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            steps_q      <= steps_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            lock_meta_q  <= pll_lock;
            lock_s_q     <= lock_meta_q;
            pll_rst      <= state_d == PRST;
            phase_step_n <= state_d != STEP;
            req_ready    <= state_d == IDLE;
            locked       <= state_d inside {IDLE, STEP, GAP, DONE};
            busy         <= state_d != IDLE;
            done         <= state_d == DONE;
            lock_lost    <= lost;
        end
    end

`ifdef PLL_PHASE_CTRL_POS_EN
    logic [4:0][15:0] pos_q;
    logic [15:0] cur;
    assign cur       = pos_q[sel_q];
    assign phase_pos = pos_q;
    always_ff @(posedge clk) begin
        if (rst || state_d == PRST) pos_q <= '0;
        else if (state_q == STEP)
            pos_q[sel_q] <= dir_q ? ((cur == 16'h7fff) ? cur : cur + 16'd1)
                                  : ((cur == 16'h8000) ? cur : cur - 16'd1);
    end
`endif
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: scoreboard bench; requests push expectations, done/lock_lost pulses pop and compare.
module tb_pll_phase_ctrl;
    localparam int GAP = 8;
    localparam int TMO = 5000;

    logic clk = 1'b0, rst = 1'b1, pll_lock = 1'b1;
    logic req_valid = 1'b0, req_dir = 1'b0;
    logic [2:0] req_sel = '0;
    logic [7:0] req_steps = '0;
    logic pll_rst, phase_dir, phase_step_n, req_ready, locked, busy, done, lock_lost;
    logic [2:0] phase_sel;
`ifdef PLL_PHASE_CTRL_POS_EN
    logic [79:0] phase_pos;
`endif

    pll_phase_ctrl #(.LOCK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .pll_rst(pll_rst),
        .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step_n(phase_step_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_dir(req_dir),
        .req_steps(req_steps), .locked(locked), .busy(busy), .done(done), .lock_lost(lock_lost)
`ifdef PLL_PHASE_CTRL_POS_EN
        , .phase_pos(phase_pos)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [2:0] sel; logic dir; int steps; int acc; logic abort;} exp_t;
    exp_t sb[$];
    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    exp_t e_m;
    int pulses = 0, last_pulse = 0, losts = 0;
    logic prev_n = 1'b1, chk_idle = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_idle) begin
                check("idle_after_done", req_ready, 1);
                chk_idle = 1'b0;
            end
            if (!phase_step_n) begin
                check("step_while_pll_rst", pll_rst, 0);
                check("step_width", prev_n, 1);
                if (pulses > 0) check("step_spacing", cyc - last_pulse, GAP + 1);
                pulses++;
                last_pulse = cyc;
            end
            prev_n = phase_step_n;
            if (done) begin
                if (sb.size() == 0) check("spurious_done", done, 0);
                else begin
                    e_m = sb.pop_front();
                    check("done_not_aborted", e_m.abort, 0);
                    check("done_latency", cyc - e_m.acc, 1 + e_m.steps * (GAP + 1));
                    check("step_count", pulses, e_m.steps);
                    check("phase_sel", phase_sel, e_m.sel);
                    check("phase_dir", phase_dir, e_m.dir);
                    check("ready_while_busy", req_ready, 0);
                    chk_idle = 1'b1;
                end
                pulses = 0;
            end
            if (lock_lost) begin
                losts++;
                check("lost_pll_rst", pll_rst, 1);
                check("lost_locked", locked, 0);
                if (sb.size() > 0) begin
                    e_m = sb.pop_front();
                    check("lost_aborts", e_m.abort, 1);
                end
                pulses = 0;
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic d, input int n, input logic ab, output int acc);
        exp_t e;
        @(negedge clk);
        req_sel = s; req_dir = d; req_steps = 8'(n); req_valid = 1'b1;
        for (int k = 0; k < 3000 && !req_ready; k++) @(negedge clk);
        check("accept_wait", req_ready, 1);
        acc = cyc;
        e.sel = (s > 3'd4) ? 3'd0 : s;
        e.dir = d; e.steps = n; e.acc = cyc; e.abort = ab;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain;
        for (int k = 0; k < 1000 && sb.size() > 0; k++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, w, l, n, p;
        logic seen;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sel", phase_sel, 0);
        check("rst_dir", phase_dir, 0);
        check("rst_step_n", phase_step_n, 1);
        check("rst_ready", req_ready, 0);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_lost", lock_lost, 0);
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin n++; @(negedge clk); end
        check("prst_len", n, 16);
        w = cyc;
        for (int k = 0; k < 2000 && !locked; k++) @(negedge clk);
        check("lock_filter_len", cyc - w, 1024);
        check("ready_on_lock", req_ready, 1);
        check("idle_busy", busy, 0);

        send(3'd1, 1'b1, 3, 1'b0, acc);
        check("sel_on_accept", phase_sel, 1);
        check("dir_on_accept", phase_dir, 1);
        drain();
        send(3'd2, 1'b0, 0, 1'b0, acc);
        drain();
        send(3'd6, 1'b1, 2, 1'b0, acc);
        drain();

        send(3'd3, 1'b0, 5, 1'b1, acc);
        p = 0;
        for (int k = 0; k < 200 && p < 2; k++) begin
            @(negedge clk);
            if (!phase_step_n) p++;
        end
        @(negedge clk);
        pll_lock = 1'b0;
        for (int k = 0; k < 50 && !lock_lost; k++) @(negedge clk);
        check("lost_seen", lock_lost, 1);
        l = cyc;
        pll_lock = 1'b1;
        send(3'd4, 1'b1, 1, 1'b0, acc);
        check("requal_latency", acc - l, 1040);
        check("locked_at_accept", locked, 1);
        drain();

        @(negedge clk);
        pll_lock = 1'b0;
        for (int k = 0; k < 50 && !lock_lost; k++) @(negedge clk);
        for (int k = 0; k < 40 && pll_rst; k++) @(negedge clk);
        w = cyc;
        seen = 1'b0;
        for (int k = 1; k <= 6000 && !pll_rst; k++) begin
            @(negedge clk);
            if (k % 100 == 0) pll_lock = ~pll_lock;
            if (locked) seen = 1'b1;
        end
        check("timeout_len", cyc - w, TMO);
        check("no_lock_while_toggling", seen, 0);
        pll_lock = 1'b1;
        for (int k = 0; k < 3000 && !locked; k++) @(negedge clk);
        check("relock", locked, 1);

`ifdef PLL_PHASE_CTRL_POS_EN
        send(3'd2, 1'b1, 4, 1'b0, acc);
        drain();
        send(3'd2, 1'b0, 6, 1'b0, acc);
        drain();
        for (int i = 0; i < 5; i++)
            check($sformatf("pos_%0d", i), phase_pos[16*i +: 16], (i == 2) ? 16'hfffe : 16'h0000);
`endif

        repeat (3) @(negedge clk);
        check("lost_count", losts, 2);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
